leitor_imagem_rom: RTL and testbench
====================================

Name: leitor_imagem_rom

Overview:
- Upstream source stage of the image-scaling datapath.
- On a start pulse, scans one frame from the source-image ROM in raster order and issues the ROM addresses itself.
- Absorbs the ROM read latency and emits a registered 8-bit pixel stream with a valid flag and frame/line markers; this stream feeds the ALU's pixel_in / pixel_in_valido.
- Supports stalling via pausa; the pixel arithmetic is left to the ALU.

Parameters:
- LARGURA, 160, source image width in pixels (>=2, even).
- ALTURA, 120, source image height in lines (>=2, even).
- ADDR_W, 15, ROM address width; LARGURA*ALTURA <= 2**ADDR_W.
- ROM_LAT, 1, ROM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- iniciar  in  1  one-cycle pulse that starts a frame scan.
- pausa  in  1  while high, no new ROM read is issued.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  8  ROM read data, valid ROM_LAT cycles after the address.
- pixel_out  out  8  pixel to the ALU.
- pixel_out_valido  out  1  pixel_out is valid this cycle.
- sof  out  1  first pixel of the frame; qualified by valid.
- eol  out  1  last pixel of a line; qualified by valid.
- eof  out  1  last pixel of the frame; qualified by valid.
- ocupado  out  1  a scan is in progress or reads are still in flight.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs go to 0, counters clear, FSM enters OCIOSO, and the valid pipeline flushes. In-flight reads are discarded; nothing emerges after reset.
- FSM states:
  - OCIOSO: iniciar=1 -> LENDO. Clear x, y and rom_addr; ocupado=1 from the next cycle.
  - LENDO: each cycle with pausa=0, issue a read (rom_addr = current address) and push a tag {sof,eol,eof} into a ROM_LAT-deep shift register with a valid bit. The address advances incrementally with no multiplier: x+1; at x=LARGURA-1, x=0 and y+1. When the read of (LARGURA-1, ALTURA-1) is issued -> DRENANDO. With pausa=1, rom_addr, x and y hold and a bubble (valid=0) is pushed.
  - DRENANDO: no new reads. Once the pipeline is empty and the last pixel has been output -> OCIOSO. ocupado falls in the cycle after eof.
- Output stage: when the tail of the shift register is valid, pixel_out <= rom_data, and the tag and valid are registered together.
- Latency: read issue to pixel_out_valido is ROM_LAT+1 cycles.
- pausa acts only on issue. Reads already in flight still reach the output; there is no backpressure on the output.
- iniciar while ocupado=1 is ignored.
- iniciar in the same cycle as rst: reset wins.
- Exactly LARGURA*ALTURA valid pixels per frame (full-resolution mode).
- sof, eol and eof are 0 whenever pixel_out_valido=0. On the last pixel of the frame, eol and eof are both 1.
- pixel_out holds its last value when not valid.

Optional Feature:
- Macro LEITOR_IMAGEM_DECIMA_EN.
- When defined: adds input port decimar (1 bit), sampled only on iniciar.
  - If decimar=1, x steps by 2 and y steps by 2, and the address advances by 2, or by LARGURA+2 at line wrap.
  - Emits (LARGURA/2)*(ALTURA/2) pixels; eol marks x=LARGURA-2 and eof marks (LARGURA-2, ALTURA-2).
  - Changing decimar mid-frame has no effect.
- When not defined: the port is absent and the block operates at full resolution only.

Decomposition:
- Shared package leitor_pkg: FSM state enumeration (OCIOSO, LENDO, DRENANDO), tag struct {sof,eol,eof}, pixel-width constant PIXEL_W=8.
- One natural sub-module: leitor_atraso_valido, a ROM_LAT-deep valid+tag shift register with flush on rst.

Test Plan (LARGURA=4, ALTURA=3, ROM_LAT=1, ROM content = address):
1. iniciar at cycle 0, pausa=0:
   - rom_addr runs 0..11 on cycles 1..12.
   - pixel_out 0..11 is valid on cycles 3..14.
   - sof on pixel 0; eol on 3, 7 and 11; eof on 11.
   - ocupado falls at cycle 15.
2. pausa high for 3 cycles after the read of addr 5 is issued:
   - Pixel 5 is still emitted.
   - Exactly 3 valid=0 cycles, then 6..11 contiguous.
   - Total count is 12.
3. iniciar pulsed again mid-frame: ignored; the stream stays 0..11 unchanged.
4. rst asserted during cycle 7 of a frame:
   - All outputs 0 and the FSM in OCIOSO on the next cycle; no valid afterwards.
   - A new iniciar yields a full fresh frame starting at pixel 0.
5. ROM_LAT=2:
   - Same stream as scenario 1, shifted one cycle later.
   - eof is still on 11 and exactly 12 pixels are emitted.
6. LEITOR_IMAGEM_DECIMA_EN with decimar=1:
   - Emits 0, 2, 8, 10.
   - eol on 2 and 10; eof on 10; 4 pixels total.

Source files
------------

// File: rtl/leitor_imagem_rom_pkg.sv
// Shared types for the image ROM reader: FSM states, per-pixel tag and pixel width.
// Optional decimation is enabled by defining LEITOR_IMAGEM_DECIMA_EN.
package leitor_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LENDO    = 2'd1,
        DRENANDO = 2'd2
    } estado_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    localparam tag_t TAG_NULO = '0;

endpackage

// File: rtl/leitor_imagem_rom_if.sv
// Bus bundle between the reader and its environment: control, ROM port and pixel stream.
// The decimar input exists only when LEITOR_IMAGEM_DECIMA_EN is defined.
interface leitor_imagem_rom_if #(
    parameter int ADDR_W = 15
);
    import leitor_pkg::*;

    logic                iniciar;
    logic                pausa;
`ifdef LEITOR_IMAGEM_DECIMA_EN
    logic                decimar;
`endif
    logic [ADDR_W-1:0]   rom_addr;
    logic [PIXEL_W-1:0]  rom_data;
    logic [PIXEL_W-1:0]  pixel_out;
    logic                pixel_out_valido;
    logic                sof;
    logic                eol;
    logic                eof;
    logic                ocupado;

    // Reader side
    modport slave (
`ifdef LEITOR_IMAGEM_DECIMA_EN
        input  decimar,
`endif
        input  iniciar,
        input  pausa,
        input  rom_data,
        output rom_addr,
        output pixel_out,
        output pixel_out_valido,
        output sof,
        output eol,
        output eof,
        output ocupado
    );

    // Environment side (controller plus ROM)
    modport master (
`ifdef LEITOR_IMAGEM_DECIMA_EN
        output decimar,
`endif
        output iniciar,
        output pausa,
        output rom_data,
        input  rom_addr,
        input  pixel_out,
        input  pixel_out_valido,
        input  sof,
        input  eol,
        input  eof,
        input  ocupado
    );

endinterface

// File: rtl/leitor_imagem_rom_atraso_valido.sv
// leitor_atraso_valido: DEPTH-stage valid+tag shift register that tracks reads in
// flight to the ROM. Reset flushes every stage so no stale read can emerge.
module leitor_atraso_valido
    import leitor_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valido,
    input  tag_t in_tag,
    output logic out_valido,
    output tag_t out_tag,
    output logic vazio
);

    logic valido_q [DEPTH];
    logic valido_d [DEPTH];
    tag_t tag_q    [DEPTH];
    tag_t tag_d    [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_estagio
            if (gi == 0) begin : g_entrada
                // Head stage takes the new read; bubbles carry a null tag
                always_comb begin
                    valido_d[gi] = in_valido;
                    tag_d[gi]    = in_valido ? in_tag : TAG_NULO;
                end
            end else begin : g_meio
                // Later stages shift from the previous one
                always_comb begin
                    valido_d[gi] = valido_q[gi-1];
                    tag_d[gi]    = tag_q[gi-1];
                end
            end

            // Stage register, flushed on reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    valido_q[gi] <= 1'b0;
                    tag_q[gi]    <= TAG_NULO;
                end else begin
                    valido_q[gi] <= valido_d[gi];
                    tag_q[gi]    <= tag_d[gi];
                end
            end
        end
    endgenerate

    // Tail drives the output stage; vazio means no read is still in flight
    always_comb begin
        out_valido = valido_q[DEPTH-1];
        out_tag    = tag_q[DEPTH-1];
        vazio      = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (valido_q[i]) begin
                vazio = 1'b0;
            end
        end
    end

endmodule

// File: rtl/leitor_imagem_rom.sv
// Source stage of the scaler: scans one frame from the image ROM in raster order,
// absorbs the ROM latency and emits a registered pixel stream with sof/eol/eof.
// Defining LEITOR_IMAGEM_DECIMA_EN adds the decimar input (2x2 subsampled scan).
module leitor_imagem_rom
    import leitor_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int ADDR_W  = 15,
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    leitor_imagem_rom_if.slave  bus
);

    localparam int X_W = (LARGURA > 2) ? $clog2(LARGURA) : 1;
    localparam int Y_W = (ALTURA  > 2) ? $clog2(ALTURA)  : 1;

    // Last coordinate visited. For the decimated scan this is the largest even
    // index, so an odd dimension still terminates on the last even line.
    localparam logic [X_W-1:0] X_ULT_CHEIO = X_W'(LARGURA - 1);
    localparam logic [Y_W-1:0] Y_ULT_CHEIO = Y_W'(ALTURA - 1);
    localparam logic [X_W-1:0] X_ULT_DEC   = X_W'(((LARGURA - 1) / 2) * 2);
    localparam logic [Y_W-1:0] Y_ULT_DEC   = Y_W'(((ALTURA - 1) / 2) * 2);

    estado_t             estado_q, estado_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                decima_q;

    logic                emite;
    tag_t                tag_emite;

    logic [X_W-1:0]      x_ult;
    logic [Y_W-1:0]      y_ult;
    logic [X_W-1:0]      x_passo;
    logic [Y_W-1:0]      y_passo;
    logic [ADDR_W-1:0]   addr_passo;
    logic [ADDR_W-1:0]   addr_passo_linha;

    logic                atraso_valido;
    tag_t                atraso_tag;
    logic                atraso_vazio;

    logic [PIXEL_W-1:0]  pixel_q, pixel_d;
    logic                valido_q, valido_d;
    tag_t                tag_out_q, tag_out_d;

`ifdef LEITOR_IMAGEM_DECIMA_EN
    logic decima_d;

    // decimar is only sampled when a scan starts, so mid-frame changes are ignored
    always_comb begin
        decima_d = decima_q;
        if (estado_q == OCIOSO && bus.iniciar) begin
            decima_d = bus.decimar;
        end
    end

    // Scan-mode register
    always_ff @(posedge clk) begin
        if (rst) begin
            decima_q <= 1'b0;
        end else begin
            decima_q <= decima_d;
        end
    end
`else
    assign decima_q = 1'b0;
`endif

    // Step sizes for the current scan mode; the address advances incrementally
    always_comb begin
        x_ult            = decima_q ? X_ULT_DEC : X_ULT_CHEIO;
        y_ult            = decima_q ? Y_ULT_DEC : Y_ULT_CHEIO;
        x_passo          = decima_q ? X_W'(2) : X_W'(1);
        y_passo          = decima_q ? Y_W'(2) : Y_W'(1);
        addr_passo       = decima_q ? ADDR_W'(2) : ADDR_W'(1);
        // From (LARGURA-2, y) to (0, y+2) is LARGURA+2 words ahead
        addr_passo_linha = decima_q ? ADDR_W'(LARGURA + 2) : ADDR_W'(1);
    end

    // Scan FSM: next state, coordinate/address update and read issue
    always_comb begin
        estado_d  = estado_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        emite     = 1'b0;
        tag_emite = TAG_NULO;
        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    estado_d = LENDO;
                    x_d      = '0;
                    y_d      = '0;
                    addr_d   = '0;
                end
            end
            LENDO: begin
                if (!bus.pausa) begin
                    emite         = 1'b1;
                    tag_emite.sof = (x_q == '0) && (y_q == '0);
                    tag_emite.eol = (x_q == x_ult);
                    tag_emite.eof = (x_q == x_ult) && (y_q == y_ult);
                    if (tag_emite.eof) begin
                        estado_d = DRENANDO;
                    end else if (x_q == x_ult) begin
                        x_d    = '0;
                        y_d    = y_q + y_passo;
                        addr_d = addr_q + addr_passo_linha;
                    end else begin
                        x_d    = x_q + x_passo;
                        addr_d = addr_q + addr_passo;
                    end
                end
            end
            DRENANDO: begin
                // The output register takes the last pixel the same cycle the
                // delay line empties, so ocupado drops right after eof
                if (atraso_vazio) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
        end else begin
            estado_q <= estado_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
        end
    end

    leitor_atraso_valido #(
        .DEPTH (ROM_LAT)
    ) u_atraso (
        .clk        (clk),
        .rst        (rst),
        .in_valido  (emite),
        .in_tag     (tag_emite),
        .out_valido (atraso_valido),
        .out_tag    (atraso_tag),
        .vazio      (atraso_vazio)
    );

    // Output stage: capture ROM data when the delay line says it is a real read
    always_comb begin
        pixel_d   = pixel_q;
        valido_d  = atraso_valido;
        tag_out_d = TAG_NULO;
        if (atraso_valido) begin
            pixel_d   = bus.rom_data;
            tag_out_d = atraso_tag;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q   <= '0;
            valido_q  <= 1'b0;
            tag_out_q <= TAG_NULO;
        end else begin
            pixel_q   <= pixel_d;
            valido_q  <= valido_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign bus.rom_addr         = addr_q;
    assign bus.pixel_out        = pixel_q;
    assign bus.pixel_out_valido = valido_q;
    assign bus.sof              = tag_out_q.sof;
    assign bus.eol              = tag_out_q.eol;
    assign bus.eof              = tag_out_q.eof;
    assign bus.ocupado          = (estado_q != OCIOSO);

endmodule

// File: tb/tb_leitor_imagem_rom.sv
// Bench for leitor_imagem_rom: 4x3 image, ROM content = address, two instances
// (ROM_LAT=1 and ROM_LAT=2) driven by the same directed control sequence.
module tb_leitor_imagem_rom;

    localparam int NC = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    leitor_imagem_rom_if #(.ADDR_W(15)) if1 ();
    leitor_imagem_rom_if #(.ADDR_W(15)) if2 ();

    leitor_imagem_rom #(.LARGURA(4), .ALTURA(3), .ADDR_W(15), .ROM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    leitor_imagem_rom #(.LARGURA(4), .ALTURA(3), .ADDR_W(15), .ROM_LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // ROM models: content equals address
    logic [7:0] rom1_q;
    logic [7:0] rom2a_q, rom2b_q;
    always_ff @(posedge clk) begin
        rom1_q  <= if1.rom_addr[7:0];
        rom2a_q <= if2.rom_addr[7:0];
        rom2b_q <= rom2a_q;
    end
    assign if1.rom_data = rom1_q;
    assign if2.rom_data = rom2b_q;

    int checks = 0;
    int errors = 0;

    logic        s_v [2][NC];
    logic [7:0]  s_p [2][NC];
    logic [2:0]  s_f [2][NC];
    logic        s_o [2][NC];
    logic [14:0] s_a [2][NC];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic ini, input logic pa, input logic dec);
        if1.iniciar = ini;  if2.iniciar = ini;
        if1.pausa   = pa;   if2.pausa   = pa;
`ifdef LEITOR_IMAGEM_DECIMA_EN
        if1.decimar = dec;  if2.decimar = dec;
`else
        if (dec) $display("decimation not built in");
`endif
    endtask

    // Cycle 0 carries iniciar; the others are optional extra events by cycle index
    task automatic run_cycles(input int pa_de, input int pa_ate, input int ini2, input int rst_c, input logic dec);
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            set_inputs((c == 0) || (c == ini2), (c >= pa_de) && (c <= pa_ate), dec);
            rst = (c == rst_c);
            @(negedge clk);
            s_v[0][c] = if1.pixel_out_valido;  s_v[1][c] = if2.pixel_out_valido;
            s_p[0][c] = if1.pixel_out;         s_p[1][c] = if2.pixel_out;
            s_f[0][c] = {if1.sof, if1.eol, if1.eof};
            s_f[1][c] = {if2.sof, if2.eol, if2.eof};
            s_o[0][c] = if1.ocupado;           s_o[1][c] = if2.ocupado;
            s_a[0][c] = if1.rom_addr;          s_a[1][c] = if2.rom_addr;
        end
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Expected frame: pixel i issued at cycle 1+i (+gap after pixel 5), emitted lat+1 later
    task automatic check_frame(input string nome, input int d, input int lat, input int dec, input int gap);
        logic       ev [NC];
        logic [7:0] ep [NC];
        logic [2:0] ef [NC];
        logic       ea [NC];
        logic [14:0] eaddr [NC];
        int npix, last_ec, cnt;
        npix = dec ? 4 : 12;
        last_ec = 0;
        cnt = 0;
        for (int c = 0; c < NC; c++) begin
            ev[c] = 1'b0; ep[c] = '0; ef[c] = '0; ea[c] = 1'b0; eaddr[c] = '0;
        end
        for (int i = 0; i < npix; i++) begin
            int ic, ec, val;
            logic eolf;
            val  = dec ? ((i / 2) * 8 + (i % 2) * 2) : i;
            eolf = dec ? (i % 2 == 1) : (i % 4 == 3);
            ic = 1 + i + ((i >= 6) ? gap : 0);
            ec = ic + lat + 1;
            ev[ec] = 1'b1;
            ep[ec] = 8'(val);
            ef[ec] = {(i == 0), eolf, (i == npix - 1)};
            ea[ic] = 1'b1;
            eaddr[ic] = 15'(val);
            last_ec = ec;
        end
        for (int c = 0; c < NC; c++) begin
            check_val($sformatf("%s d%0d c%0d valid", nome, d, c), 32'(s_v[d][c]), 32'(ev[c]));
            check_val($sformatf("%s d%0d c%0d flags", nome, d, c), 32'(s_f[d][c]), 32'(ef[c]));
            check_val($sformatf("%s d%0d c%0d ocupado", nome, d, c), 32'(s_o[d][c]),
                      32'((c >= 1) && (c <= last_ec)));
            if (ev[c]) check_val($sformatf("%s d%0d c%0d pixel", nome, d, c), 32'(s_p[d][c]), 32'(ep[c]));
            if (ea[c]) check_val($sformatf("%s d%0d c%0d rom_addr", nome, d, c), 32'(s_a[d][c]), 32'(eaddr[c]));
            if (s_v[d][c]) cnt++;
        end
        check_val($sformatf("%s d%0d count", nome, d), 32'(cnt), 32'(npix));
        $display("%s: dut%0d (ROM_LAT=%0d) emitted %0d pixels, last at cycle %0d", nome, d + 1, lat, cnt, last_ec);
    endtask

    // After a reset at cycle rst_c, everything is quiet from the next cycle on
    task automatic check_quiet(input string nome, input int d, input int from_c);
        for (int c = from_c; c < NC; c++) begin
            check_val($sformatf("%s d%0d c%0d valid", nome, d, c), 32'(s_v[d][c]), 32'd0);
            check_val($sformatf("%s d%0d c%0d flags", nome, d, c), 32'(s_f[d][c]), 32'd0);
            check_val($sformatf("%s d%0d c%0d ocupado", nome, d, c), 32'(s_o[d][c]), 32'd0);
        end
        check_val($sformatf("%s d%0d pixel_after_rst", nome, d), 32'(s_p[d][from_c]), 32'd0);
        check_val($sformatf("%s d%0d addr_after_rst", nome, d), 32'(s_a[d][from_c]), 32'd0);
        $display("%s: dut%0d quiet from cycle %0d", nome, d + 1, from_c);
    endtask

    initial begin
        set_inputs(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("reset valid1", 32'(if1.pixel_out_valido), 32'd0);
        check_val("reset ocupado1", 32'(if1.ocupado), 32'd0);
        check_val("reset addr1", 32'(if1.rom_addr), 32'd0);
        check_val("reset pixel1", 32'(if1.pixel_out), 32'd0);
        check_val("reset flags2", 32'({if2.sof, if2.eol, if2.eof}), 32'd0);
        check_val("reset valid2", 32'(if2.pixel_out_valido), 32'd0);
        $display("reset: outputs idle");

        // rst and iniciar together: reset wins, nothing starts
        run_cycles(-1, -2, -1, 0, 1'b0);
        check_quiet("rst_ini", 0, 1);
        check_quiet("rst_ini", 1, 1);

        // Plain full frame
        run_cycles(-1, -2, -1, -1, 1'b0);
        check_frame("full", 0, 1, 0, 0);
        check_frame("full", 1, 2, 0, 0);

        // pausa for 3 cycles right after the read of addr 5
        run_cycles(7, 9, -1, -1, 1'b0);
        check_frame("pausa", 0, 1, 0, 3);
        check_frame("pausa", 1, 2, 0, 3);

        // Second iniciar mid-frame is ignored
        run_cycles(-1, -2, 5, -1, 1'b0);
        check_frame("ini2", 0, 1, 0, 0);
        check_frame("ini2", 1, 2, 0, 0);

        // Reset during cycle 7, then a fresh frame
        run_cycles(-1, -2, -1, 7, 1'b0);
        check_quiet("rst_mid", 0, 8);
        check_quiet("rst_mid", 1, 8);
        run_cycles(-1, -2, -1, -1, 1'b0);
        check_frame("fresh", 0, 1, 0, 0);
        check_frame("fresh", 1, 2, 0, 0);

`ifdef LEITOR_IMAGEM_DECIMA_EN
        run_cycles(-1, -2, -1, -1, 1'b1);
        check_frame("decima", 0, 1, 1, 0);
        check_frame("decima", 1, 2, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
